obstacle_collide: RTL and testbench

//   Consumer of the obstacle slot bus (en'type<4>'col<10>) and the BCD score produced by the obstacle controller.
//   On each game tick it snapshots the three slots and the dino pose, then checks one slot per clock for a hitbox overlap.

---
 rtl/obstacle_collide.sv | 207 ++++++++++++++++++++
 tb/tb_obstacle_collide.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_collide.sv
// obstacle_collide: snapshots the three obstacle slots and the dino pose on a
// game tick, tests one slot per clock for a hitbox overlap, and then raises
// the sticky game-over flag and updates the BCD high score.
// Optional build macro: COLLIDE_GOD_MODE_EN adds a 'god' input. While it is
// high, hits are still reported on hit_slot, but over and hi_score are left alone.
`timescale 1ns/1ps

module obstacle_collide #(
    parameter int DINO_X     = 50,
    parameter int HIT_MARGIN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_tick,
    input  logic        restart,
    input  logic [14:0] obstacle1,
    input  logic [14:0] obstacle2,
    input  logic [14:0] obstacle3,
    input  logic [8:0]  dino_h,
    input  logic        dino_duck,
`ifdef COLLIDE_GOD_MODE_EN
    input  logic        god,
`endif
    input  logic [15:0] score,
    output logic        over,
    output logic [1:0]  hit_slot,
    output logic [15:0] hi_score,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CHK1 = 3'd1,
        S_CHK2 = 3'd2,
        S_CHK3 = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // All coordinates are 11 bits wide, so col + width can never wrap.
    localparam logic [10:0] DX_LO  = 11'(DINO_X);
    localparam logic [10:0] MARGIN = 11'(HIT_MARGIN);

    // Half-open interval overlap, with both ends pulled in by the margin.
    function automatic logic overlap(input logic [10:0] a_lo, input logic [10:0] a_hi,
                                     input logic [10:0] b_lo, input logic [10:0] b_hi);
        return ((a_lo + MARGIN) < b_hi) && ((b_lo + MARGIN) < a_hi);
    endfunction

    // Full hitbox test of one obstacle slot against the dino pose.
    function automatic logic box_hit(input logic [14:0] obs, input logic [8:0] h,
                                     input logic duck);
        logic        kind_ok;
        logic [10:0] ox_lo;
        logic [10:0] ow;
        logic [10:0] oy_lo;
        logic [10:0] oy_hi;
        logic [10:0] dx_hi;
        logic [10:0] dy_lo;
        logic [10:0] dy_hi;
        kind_ok = 1'b1;
        ow      = '0;
        oy_lo   = '0;
        oy_hi   = '0;
        case (obs[13:10])
            4'd1:    begin ow = 11'd17;  oy_hi = 11'd35; end
            4'd2:    begin ow = 11'd34;  oy_hi = 11'd35; end
            4'd3:    begin ow = 11'd51;  oy_hi = 11'd35; end
            4'd5:    begin ow = 11'd125; oy_hi = 11'd50; end
            4'd6:    begin ow = 11'd150; oy_hi = 11'd50; end
            4'd7:    begin ow = 11'd175; oy_hi = 11'd50; end
            4'd9:    begin ow = 11'd46;  oy_lo = 11'd10; oy_hi = 11'd50;  end
            4'd10:   begin ow = 11'd46;  oy_lo = 11'd40; oy_hi = 11'd80;  end
            4'd11:   begin ow = 11'd46;  oy_lo = 11'd80; oy_hi = 11'd120; end
            default: kind_ok = 1'b0;
        endcase
        ox_lo = {1'b0, obs[9:0]};
        dx_hi = duck ? (DX_LO + 11'd59) : (DX_LO + 11'd44);
        dy_lo = {2'b00, h};
        dy_hi = duck ? (dy_lo + 11'd30) : (dy_lo + 11'd47);
        return obs[14] && kind_ok
            && overlap(DX_LO, dx_hi, ox_lo, ox_lo + ow)
            && overlap(dy_lo, dy_hi, oy_lo, oy_hi);
    endfunction

    state_t      state_q, state_d;
    logic        over_q, over_d;
    logic [1:0]  hit_slot_q, hit_slot_d;
    logic [1:0]  found_q, found_d;
    logic [15:0] hi_score_q, hi_score_d;
    logic [8:0]  snap_h_q;
    logic        snap_duck_q;
    logic        start_scan;
    logic        god_on;
    logic [2:0]  slot_hit;
    logic [2:0][14:0] obs_in;

`ifdef COLLIDE_GOD_MODE_EN
    assign god_on = god;
`else
    assign god_on = 1'b0;
`endif

    assign obs_in = {obstacle3, obstacle2, obstacle1};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_slot
            logic [14:0] obs_q;

            // Capture this slot when a scan starts; it stays frozen for the scan.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    obs_q <= '0;
                end else if (start_scan) begin
                    obs_q <= obs_in[gi];
                end
            end

            assign slot_hit[gi] = box_hit(obs_q, snap_h_q, snap_duck_q);
        end
    endgenerate

    // Capture the dino pose alongside the obstacle slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_h_q    <= '0;
            snap_duck_q <= 1'b0;
        end else if (start_scan) begin
            snap_h_q    <= dino_h;
            snap_duck_q <= dino_duck;
        end
    end

    // Scan sequencing: start on an accepted tick, test one slot per state,
    // keep the first hit, and commit the result in DONE.
    always_comb begin
        state_d    = state_q;
        over_d     = over_q;
        hit_slot_d = hit_slot_q;
        found_d    = found_q;
        hi_score_d = hi_score_q;
        start_scan = 1'b0;
        if (restart) begin
            state_d    = S_IDLE;
            over_d     = 1'b0;
            hit_slot_d = 2'd0;
            found_d    = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (game_tick && !over_q) begin
                        start_scan = 1'b1;
                        found_d    = 2'd0;
                        state_d    = S_CHK1;
                    end
                end
                S_CHK1: begin
                    if (found_q == 2'd0 && slot_hit[0]) found_d = 2'd1;
                    state_d = S_CHK2;
                end
                S_CHK2: begin
                    if (found_q == 2'd0 && slot_hit[1]) found_d = 2'd2;
                    state_d = S_CHK3;
                end
                S_CHK3: begin
                    if (found_q == 2'd0 && slot_hit[2]) found_d = 2'd3;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    if (found_q != 2'd0) begin
                        hit_slot_d = found_q;
                        if (!god_on) begin
                            over_d = 1'b1;
                            // A BCD value orders the same way as its binary pattern.
                            if (score > hi_score_q) hi_score_d = score;
                        end
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and result registers; a reset aborts any scan at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            over_q     <= 1'b0;
            hit_slot_q <= 2'd0;
            found_q    <= 2'd0;
            hi_score_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            over_q     <= over_d;
            hit_slot_q <= hit_slot_d;
            found_q    <= found_d;
            hi_score_q <= hi_score_d;
        end
    end

    assign over     = over_q;
    assign hit_slot = hit_slot_q;
    assign hi_score = hi_score_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_obstacle_collide.sv
// Testbench for obstacle_collide. Expected results come from a hitbox model
// written directly from the geometry rules. They go into a queue, and a monitor
// compares them whenever a scan finishes (busy falls).
`timescale 1ns/1ps

module tb_obstacle_collide;

    logic        clk = 1'b0;
    logic        rst;
    logic        game_tick;
    logic        restart;
    logic [14:0] obs1, obs2, obs3;
    logic [8:0]  dino_h;
    logic        dino_duck;
    logic [15:0] score;
    logic        over;
    logic [1:0]  hit_slot;
    logic [15:0] hi_score;
    logic        busy;
`ifdef COLLIDE_GOD_MODE_EN
    logic        god = 1'b0;
`endif

    always #5 clk = ~clk;

    obstacle_collide dut (
        .clk       (clk),
        .rst       (rst),
        .game_tick (game_tick),
        .restart   (restart),
        .obstacle1 (obs1),
        .obstacle2 (obs2),
        .obstacle3 (obs3),
        .dino_h    (dino_h),
        .dino_duck (dino_duck),
`ifdef COLLIDE_GOD_MODE_EN
        .god       (god),
`endif
        .score     (score),
        .over      (over),
        .hit_slot  (hit_slot),
        .hi_score  (hi_score),
        .busy      (busy)
    );

    typedef struct {
        logic        over;
        logic [1:0]  slot;
        logic [15:0] hi;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   txn   = 0;

    // Model state
    bit          over_m = 1'b0;
    logic [1:0]  slot_m = 2'd0;
    logic [15:0] hi_m   = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Geometry straight from the rules: boxes are half-open, shrunk by 4 px.
    function automatic bit model_hit(input logic [14:0] o, input int h, input bit duck);
        int t, col, w, ylo, yhi, dxhi, dyhi;
        t   = int'(o[13:10]);
        col = int'(o[9:0]);
        if (!o[14]) return 1'b0;
        if (t >= 1 && t <= 3) begin
            w = 17 * t; ylo = 0; yhi = 35;
        end else if (t >= 5 && t <= 7) begin
            w = 25 * t; ylo = 0; yhi = 50;
        end else if (t >= 9 && t <= 11) begin
            w = 46; ylo = (t == 9) ? 10 : (t == 10) ? 40 : 80; yhi = ylo + 40;
        end else begin
            return 1'b0;
        end
        dxhi = 50 + (duck ? 59 : 44);
        dyhi = h + (duck ? 30 : 47);
        return (54 < col + w) && (col + 4 < dxhi) && (h + 4 < yhi) && (ylo + 4 < dyhi);
    endfunction

    // Monitor: each time busy falls outside reset, one scan result is due.
    initial begin : monitor
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (prev && !busy) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_scan: got a finished scan, wanted none (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        txn++;
                        $display("txn %0d: over=%0d hit_slot=%0d hi_score=%h cyc=%0d",
                                 txn, over, hit_slot, hi_score, cyc);
                        chk("sb_over", 32'(over), 32'(e.over));
                        chk("sb_hit_slot", 32'(hit_slot), 32'(e.slot));
                        chk("sb_hi_score", 32'(hi_score), 32'(e.hi));
                        chk("sb_latency", 32'(cyc), 32'(e.cyc));
                    end
                end
                prev = busy;
            end
        end
    end

    // One tick attempt. Optionally fire a second tick mid-scan, assert reset
    // mid-scan, or scramble the inputs after the snapshot is taken.
    task automatic scan(input bit mid_tick, input bit mid_rst, input bit scramble);
        bit   accepted;
        int   first;
        int   t0;
        exp_t e;
        @(posedge clk); #1;
        game_tick = 1'b1;
        @(posedge clk); #1;
        game_tick = 1'b0;
        t0 = cyc;
        accepted = !over_m;
        if (accepted) begin
            first = 0;
            if (model_hit(obs3, int'(dino_h), dino_duck)) first = 3;
            if (model_hit(obs2, int'(dino_h), dino_duck)) first = 2;
            if (model_hit(obs1, int'(dino_h), dino_duck)) first = 1;
            if (first != 0) begin
                slot_m = 2'(first);
                over_m = 1'b1;
                if (score > hi_m) hi_m = score;
            end
            e.over = over_m; e.slot = slot_m; e.hi = hi_m; e.cyc = t0 + 4;
            exp_q.push_back(e);
        end
        if (scramble) begin
            obs1 = 15'($urandom); obs2 = 15'($urandom); obs3 = 15'($urandom);
            dino_h = 9'($urandom); dino_duck = 1'($urandom);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (mid_rst && k == 0) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_over", 32'(over), 32'd0);
                chk("rst_hit_slot", 32'(hit_slot), 32'd0);
                chk("rst_hi_score", 32'(hi_score), 32'd0);
                exp_q.delete();
                over_m = 1'b0; slot_m = 2'd0; hi_m = 16'd0;
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            if (mid_tick && k == 0) game_tick = 1'b1;
            if (mid_tick && k == 1) game_tick = 1'b0;
            if (accepted) chk("busy_window", 32'(busy), (k < 3) ? 32'd1 : 32'd0);
            else          chk("ignored_busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic do_restart();
        @(posedge clk); #1;
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        over_m = 1'b0;
        slot_m = 2'd0;
        chk("restart_over", 32'(over), 32'd0);
        chk("restart_hit_slot", 32'(hit_slot), 32'd0);
        chk("restart_hi_kept", 32'(hi_score), 32'(hi_m));
    endtask

    function automatic logic [15:0] rand_bcd();
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    function automatic logic [14:0] rand_slot();
        return {1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                10'($urandom_range(0, 160))};
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        rst = 1'b1; game_tick = 1'b0; restart = 1'b0;
        obs1 = '0; obs2 = '0; obs3 = '0;
        dino_h = '0; dino_duck = 1'b0; score = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_over", 32'(over), 32'd0);
        chk("reset_hit_slot", 32'(hit_slot), 32'd0);
        chk("reset_hi_score", 32'(hi_score), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Small cactus right in front of a standing dino.
        obs1 = {1'b1, 4'd1, 10'd60};
        scan(1'b0, 1'b0, 1'b0);
        chk("t1_over", 32'(over), 32'd1);
        chk("t1_hit_slot", 32'(hit_slot), 32'd1);
        do_restart();

        // Jumping clears the cactus.
        dino_h = 9'd40;
        scan(1'b0, 1'b0, 1'b0);
        chk("t2_over", 32'(over), 32'd0);
        chk("t2_hit_slot", 32'(hit_slot), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);

        // A mid-height bird hits a standing dino but not a ducking one.
        obs1 = '0; obs2 = {1'b1, 4'd10, 10'd60}; dino_h = 9'd0; dino_duck = 1'b0;
        scan(1'b0, 1'b0, 1'b0);
        chk("t3_over", 32'(over), 32'd1);
        chk("t3_hit_slot", 32'(hit_slot), 32'd2);
        do_restart();
        dino_duck = 1'b1;
        scan(1'b0, 1'b0, 1'b0);
        chk("t3_duck_over", 32'(over), 32'd0);

        // Two slots hit at once; the lower index wins.
        obs1 = {1'b0, 4'd5, 10'd55}; obs2 = {1'b1, 4'd5, 10'd55}; obs3 = {1'b1, 4'd5, 10'd55};
        dino_duck = 1'b0;
        scan(1'b0, 1'b0, 1'b0);
        chk("t4_hit_slot", 32'(hit_slot), 32'd2);
        do_restart();

        // High score is loaded on a hit and kept over a lower score.
        obs1 = {1'b1, 4'd1, 10'd60}; obs2 = '0; obs3 = '0; score = 16'h0123;
        scan(1'b0, 1'b0, 1'b0);
        chk("t5_hi_load", 32'(hi_score), 32'h0123);
        do_restart();
        score = 16'h0099;
        scan(1'b0, 1'b0, 1'b0);
        chk("t5_hi_keep", 32'(hi_score), 32'h0123);
        chk("t5_over", 32'(over), 32'd1);

        // Ticks while over=1 start nothing.
        scan(1'b0, 1'b0, 1'b0);
        chk("t6_over_held", 32'(over), 32'd1);
        do_restart();

        // A second tick during the scan is ignored.
        scan(1'b1, 1'b0, 1'b0);
        chk("t6_midtick_over", 32'(over), 32'd1);
        do_restart();

        // Reset in the middle of a scan aborts it.
        scan(1'b0, 1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("t6_after_rst_busy", 32'(busy), 32'd0);

        // Randomized scans with inputs changing under the snapshot.
        for (int n = 0; n < 150; n++) begin
            obs1 = rand_slot(); obs2 = rand_slot(); obs3 = rand_slot();
            dino_h = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(0, 130));
            dino_duck = 1'($urandom);
            score = rand_bcd();
            if (over_m && $urandom_range(0, 3) != 0) do_restart();
            scan($urandom_range(0, 7) == 0, 1'b0, 1'b1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
